oled_init_sequencer: RTL and testbench

Sequences the OLED panel's power-up: drives the panel reset pulse, then walks a table of (register, data) pairs and issues each as an I2C register write through the byte-level I2C transaction engine. With `VERIFY=1`, each write is followed by a read-back of the same register. A failed ACK or a mismatch retries the entry, up to a limit. The block sits between the top-level power-up logic and the I2C engine, and replaces single hard-coded register writes.

---
 rtl/oled_init_sequencer.sv | 176 +++++++++++++++++
 tb/tb_oled_init_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_init_sequencer.sv
// OLED power-up sequencer: drives the panel reset pulse, then issues a table of
// I2C register writes, optionally reading each back, retrying failed entries.
module oled_init_sequencer #(
  parameter logic [6:0] SLV_ADDR  = 7'b1010100,
  parameter int         NUM_CMDS  = 16,
  parameter int         RST_DELAY = 1500000,
  parameter int         MAX_RETRY = 3,
  parameter int         VERIFY    = 1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        start_i,
  output logic [7:0]  tbl_addr_o,
  input  logic [15:0] tbl_data_i,
  output logic        req_o,
  output logic        rnw_o,
  output logic [6:0]  slv_addr_o,
  output logic [7:0]  reg_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic        done_i,
  input  logic        ack_err_i,
  input  logic [7:0]  rd_data_i,
  output logic        oled_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  fail_idx_o
);
  localparam logic [31:0] DLY_LAST  = 32'(RST_DELAY - 1);
  localparam logic [8:0]  IDX_END   = 9'(NUM_CMDS);
  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_PRE, S_RST_LOW, S_RST_POST, S_FETCH, S_WR_REQ, S_WR_WAIT,
    S_RD_REQ, S_RD_WAIT, S_RETRY, S_NEXT, S_DONE, S_FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] dly_q, dly_d;
  // One bit wider than the table address so NUM_CMDS=256 still terminates.
  logic [8:0]  idx_q, idx_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] entry_q, entry_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  slv_q, slv_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  fidx_q, fidx_d;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      entry_q <= '0;
      rnw_q   <= 1'b0;
      slv_q   <= '0;
      reg_q   <= '0;
      wdat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      entry_q <= entry_d;
      rnw_q   <= rnw_d;
      slv_q   <= slv_d;
      reg_q   <= reg_d;
      wdat_q  <= wdat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    entry_d = entry_q;
    rnw_d   = rnw_q;
    slv_d   = slv_q;
    reg_d   = reg_q;
    wdat_d  = wdat_q;
    done_d  = done_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_RST_PRE;
        dly_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fidx_d  = '0;
      end
      S_RST_PRE, S_RST_LOW, S_RST_POST: begin
        if (dly_q == DLY_LAST) begin
          dly_d = '0;
          case (state_q)
            S_RST_PRE: state_d = S_RST_LOW;
            S_RST_LOW: state_d = S_RST_POST;
            default: begin
              state_d = S_FETCH;
              idx_d   = '0;
            end
          endcase
        end else begin
          dly_d = dly_q + 32'd1;
        end
      end
      S_FETCH: begin
        entry_d = tbl_data_i;
        if (idx_q == IDX_END || tbl_data_i == 16'hFFFF) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WR_REQ;
          retry_d = '0;
        end
      end
      S_WR_REQ:  state_d = S_WR_WAIT;
      S_WR_WAIT: if (done_i) begin
        if (ack_err_i)        state_d = S_RETRY;
        else if (VERIFY != 0) state_d = S_RD_REQ;
        else                  state_d = S_NEXT;
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: if (done_i) begin
        if (ack_err_i || rd_data_i != entry_q[7:0]) state_d = S_RETRY;
        else                                         state_d = S_NEXT;
      end
      S_RETRY: begin
        retry_d = retry_q + 4'd1;
        state_d = (retry_d == RETRY_LIM) ? S_FAIL : S_WR_REQ;
      end
      S_NEXT: begin
        idx_d   = idx_q + 9'd1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    // Request qualifiers are captured on entry so they are valid with req_o and
    // hold until the next request.
    if (state_d == S_WR_REQ) begin
      rnw_d  = 1'b0;
      slv_d  = SLV_ADDR;
      reg_d  = entry_d[15:8];
      wdat_d = entry_d[7:0];
    end
    if (state_d == S_RD_REQ) rnw_d = 1'b1;
    if (state_d == S_DONE) done_d = 1'b1;
    if (state_d == S_FAIL) begin
      err_d  = 1'b1;
      fidx_d = idx_q[7:0];
    end
  end

  assign tbl_addr_o = idx_q[7:0];
  assign req_o      = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign rnw_o      = rnw_q;
  assign slv_addr_o = slv_q;
  assign reg_addr_o = reg_q;
  assign wr_data_o  = wdat_q;
  assign oled_rst_o = (state_q != S_RST_LOW);
  assign busy_o     = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign fail_idx_o = fidx_q;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Bench: two sequencer instances (VERIFY=0/NUM_CMDS=16, VERIFY=1/NUM_CMDS=2)
// driven by a scripted I2C engine and checked against a transaction-level model.
`timescale 1ns/1ps
module tb_oled_init_sequencer;
  localparam int D   = 4;
  localparam int MR  = 3;
  localparam int TMO = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst = 2'b11, start = 2'b00;
  logic [1:0]       req, rnw, oled, busy, dn, er;
  logic [1:0]       done_v = '0, ack_v = '0;
  logic [1:0][7:0]  taddr, rg, wd, fidx;
  logic [1:0][7:0]  rd_v = '0;
  logic [1:0][6:0]  slv;
  logic [1:0][15:0] tdat;
  logic [15:0]      tbl [2][8];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    oled_init_sequencer #(
      .NUM_CMDS(g == 0 ? 16 : 2), .RST_DELAY(D), .MAX_RETRY(MR), .VERIFY(g)
    ) u_dut (
      .sys_clk_i(clk), .sys_rst_i(rst[g]), .start_i(start[g]),
      .tbl_addr_o(taddr[g]), .tbl_data_i(tdat[g]),
      .req_o(req[g]), .rnw_o(rnw[g]), .slv_addr_o(slv[g]),
      .reg_addr_o(rg[g]), .wr_data_o(wd[g]),
      .done_i(done_v[g]), .ack_err_i(ack_v[g]), .rd_data_i(rd_v[g]),
      .oled_rst_o(oled[g]), .busy_o(busy[g]), .done_o(dn[g]), .err_o(er[g]),
      .fail_idx_o(fidx[g])
    );
  end

  always_comb
    for (int g = 0; g < 2; g++)
      tdat[g] = (taddr[g] < 8'd8) ? tbl[g][taddr[g][2:0]] : 16'hFFFF;

  // Scenario configuration, written only by the stimulus process.
  int         act = 0;
  logic       nack_en = 1'b0;
  logic [7:0] nack_reg = '0, bad_reg = '0;
  int         bad_n = 0;
  int         lit_nwr, lit_nrd;
  logic       lit_done, lit_err;
  logic [7:0] lit_fidx;

  // I2C engine: completes each request 4 cycles later, NACKs writes to nack_reg,
  // corrupts the first bad_n reads of bad_reg.
  logic [1:0]      pend = '0, p_rnw = '0;
  logic [1:0][7:0] p_reg;
  int              cnt [2];
  int              bad_used [2];
  logic [7:0]      mem [2][256];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      done_v[g] <= 1'b0;
      if (rst[g]) begin
        pend[g]     <= 1'b0;
        bad_used[g] <= 0;
      end else if (req[g]) begin
        pend[g]  <= 1'b1;
        cnt[g]   <= 2;
        p_rnw[g] <= rnw[g];
        p_reg[g] <= rg[g];
        if (!rnw[g] && !(nack_en && rg[g] == nack_reg)) mem[g][rg[g]] <= wd[g];
      end else if (pend[g]) begin
        if (cnt[g] == 0) begin
          pend[g]   <= 1'b0;
          done_v[g] <= 1'b1;
          ack_v[g]  <= !p_rnw[g] && nack_en && p_reg[g] == nack_reg;
          if (p_rnw[g] && p_reg[g] == bad_reg && bad_used[g] < bad_n) begin
            rd_v[g]     <= mem[g][p_reg[g]] ^ 8'h01;
            bad_used[g] <= bad_used[g] + 1;
          end else begin
            rd_v[g] <= p_rnw[g] ? mem[g][p_reg[g]] : 8'h00;
          end
        end else begin
          cnt[g] <= cnt[g] - 1;
        end
      end
    end
  end

  // Expected transactions; gap = cycles from the previous done_i (0: first request).
  typedef struct packed {
    logic       rnw;
    logic [7:0] idx;
    logic [7:0] rg;
    logic [7:0] dt;
    logic [3:0] gap;
  } txn_t;

  txn_t       q[$];
  txn_t       t;
  logic       exp_done, exp_err;
  logic [7:0] exp_fidx;
  int         n_chk = 0, n_pass = 0, fin_cnt = 0;
  int         k, since_done, n_wr, n_rd, n_low;
  logic       running = 1'b0, arm = 1'b0, rst_prev = 1'b1, have_last = 1'b0;
  logic       sticky_d = 1'b0, sticky_e = 1'b0;
  logic [23:0] last_q;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic push(logic r, int i, logic [15:0] e, int gap);
    txn_t x;
    x.rnw = r; x.idx = 8'(i); x.rg = e[15:8]; x.dt = e[7:0]; x.gap = 4'(gap);
    q.push_back(x);
  endtask

  task automatic build(int g);
    int ncmd, used, gap;
    logic [15:0] e;
    logic ok;
    ncmd = (g == 0) ? 16 : 2;
    used = 0;
    gap  = 0;
    q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_fidx = '0;
    for (int i = 0; i < ncmd; i++) begin
      e = (i < 8) ? tbl[g][i] : 16'hFFFF;
      if (e == 16'hFFFF) break;
      ok = 1'b0;
      for (int a = 0; a < MR && !ok; a++) begin
        push(1'b0, i, e, gap);
        gap = 2;
        if (nack_en && e[15:8] == nack_reg) continue;
        if (g == 1) begin
          push(1'b1, i, e, 1);
          if (e[15:8] == bad_reg && used < bad_n) begin
            used++;
            continue;
          end
        end
        ok = 1'b1;
      end
      if (!ok) begin
        exp_err  = 1'b1;
        exp_fidx = 8'(i);
        return;
      end
      gap = 3;
    end
    exp_done = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_prev) begin
      chk("rst_oled", oled[act], 1);
      chk("rst_flags", {busy[act], dn[act], er[act], req[act], rnw[act]}, 0);
      chk("rst_bus", {taddr[act], rg[act], wd[act], slv[act], fidx[act]}, 0);
      running = 1'b0; have_last = 1'b0; sticky_d = 1'b0; sticky_e = 1'b0;
      q.delete();
    end else begin
      if (arm) begin
        build(act);
        running = 1'b1; k = 0; since_done = 0; n_wr = 0; n_rd = 0; n_low = 0;
        chk("start_clears", {dn[act], er[act], fidx[act]}, 0);
      end
      if (running) begin
        since_done++;
        chk("oled_rst", oled[act], (k >= D && k < 2 * D) ? 0 : 1);
        if (!oled[act]) n_low++;
        if (k <= 3 * D) begin
          chk("busy_prefetch", busy[act], 1);
          chk("req_early", req[act], 0);
        end
        if (req[act]) begin
          if (q.size() == 0) begin
            chk("extra_req", 1, 0);
          end else begin
            t = q.pop_front();
            chk("req_rnw", rnw[act], t.rnw);
            chk("req_reg", rg[act], t.rg);
            chk("req_data", wd[act], t.dt);
            chk("req_slv", slv[act], 7'h54);
            chk("req_idx", taddr[act], t.idx);
            if (t.gap == 0) chk("first_req_cycle", k, 3 * D + 1);
            else            chk("req_gap", since_done, t.gap);
          end
          if (rnw[act]) n_rd++; else n_wr++;
          last_q    = {rnw[act], slv[act], rg[act], wd[act]};
          have_last = 1'b1;
        end else if (have_last) begin
          chk("qual_stable", {rnw[act], slv[act], rg[act], wd[act]}, last_q);
        end
        if (done_v[act]) since_done = 0;
        if (!busy[act] && k > 3 * D) begin
          chk("fin_done", dn[act], exp_done);
          chk("fin_err", er[act], exp_err);
          chk("fin_fidx", fidx[act], exp_fidx);
          chk("fin_leftover", q.size(), 0);
          chk("lit_writes", n_wr, lit_nwr);
          chk("lit_reads", n_rd, lit_nrd);
          chk("lit_low_cycles", n_low, D);
          chk("lit_flags", {dn[act], er[act], fidx[act]}, {lit_done, lit_err, lit_fidx});
          sticky_d = exp_done; sticky_e = exp_err;
          running = 1'b0;
          fin_cnt++;
        end else if (k > TMO) begin
          chk("timeout", k, 0);
          running = 1'b0;
          fin_cnt++;
        end
        k++;
      end else begin
        chk("idle_quiet", {busy[act], req[act]}, 0);
        chk("idle_sticky", {dn[act], er[act]}, {sticky_d, sticky_e});
      end
    end
    arm      = !rst[act] && start[act] && !running;
    rst_prev = rst[act];
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic prep(int g, logic [15:0] t0, logic [15:0] t1, logic [15:0] t2,
                      logic ne, logic [7:0] nr, logic [7:0] br, int bn,
                      int lw, int lr, logic ld, logic le, logic [7:0] lf);
    rst = 2'b11;
    tick(1);
    act = g;
    for (int i = 0; i < 8; i++) tbl[g][i] = 16'hFFFF;
    tbl[g][0] = t0; tbl[g][1] = t1; tbl[g][2] = t2;
    nack_en = ne; nack_reg = nr; bad_reg = br; bad_n = bn;
    lit_nwr = lw; lit_nrd = lr; lit_done = ld; lit_err = le; lit_fidx = lf;
    tick(2);
    rst[g] = 1'b0;
    tick(2);
  endtask

  task automatic go();
    start[act] = 1'b1;
    tick(1);
    start[act] = 1'b0;
  endtask

  task automatic wait_fin(int f0);
    for (int i = 0; i < 3000 && fin_cnt == f0; i++) tick(1);
    if (fin_cnt == f0) begin
      $display("FAIL wait_fin: no completion seen, fin_cnt %0d", fin_cnt);
      $fatal(1);
    end
  endtask

  initial begin
    int f0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 8; i++) tbl[g][i] = 16'hFFFF;
    tick(4);

    // VERIFY=0, end marker after two entries; start pulses while busy are ignored.
    prep(0, 16'h0100, 16'h020B, 16'hFFFF, 1'b0, 8'h00, 8'h00, 0, 2, 0, 1'b1, 1'b0, 8'd0);
    f0 = fin_cnt;
    go();
    tick(D + 2);
    go();
    tick(3 * D);
    go();
    wait_fin(f0);
    tick(4);

    // VERIFY=1, first read-back of reg 0x02 returns 0x0A: write, read, write, read.
    prep(1, 16'h0100, 16'h020B, 16'hFFFF, 1'b0, 8'h00, 8'h02, 1, 3, 3, 1'b1, 1'b0, 8'd0);
    f0 = fin_cnt;
    go();
    wait_fin(f0);
    tick(4);

    // Every write to reg 0x02 NACKed: three attempts at index 1, then fail.
    prep(0, 16'h0100, 16'h0233, 16'hFFFF, 1'b1, 8'h02, 8'h00, 0, 4, 0, 1'b0, 1'b1, 8'd1);
    f0 = fin_cnt;
    go();
    wait_fin(f0);
    tick(4);

    // NUM_CMDS=2 with no end marker: only two entries issued.
    prep(1, 16'h0100, 16'h020B, 16'h0307, 1'b0, 8'h00, 8'h00, 0, 2, 2, 1'b1, 1'b0, 8'd0);
    f0 = fin_cnt;
    go();
    wait_fin(f0);
    tick(4);

    // Reset during RD_WAIT (with a coincident start), then restart from scratch.
    prep(1, 16'h0100, 16'h020B, 16'hFFFF, 1'b0, 8'h00, 8'h00, 0, 2, 2, 1'b1, 1'b0, 8'd0);
    f0 = fin_cnt;
    go();
    for (int i = 0; i < 200 && !(req[1] && rnw[1]); i++) tick(1);
    tick(1);
    rst[1]   = 1'b1;
    start[1] = 1'b1;
    tick(1);
    rst[1]   = 1'b0;
    start[1] = 1'b0;
    tick(1);
    go();
    wait_fin(f0);
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
